fsm_16bit_split: RTL

//   Splits one IN_W-bit word into two OUT_W-bit halves and emits them one per

---
 rtl/fsm_16bit_split_if.sv | 34 +++
 rtl/fsm_16bit_split.sv | 104 ++++++++++
 2 files changed

// File: rtl/fsm_16bit_split_if.sv
// Word-in / half-word-out stream bundle for the word splitter.
// master is the producer+consumer side, slave is the splitter.
interface fsm_16bit_split_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
);
    logic             data_in_valid;
    logic [IN_W-1:0]  data_in;
    logic             data_in_ready;
    logic [OUT_W-1:0] data_out;
    logic             output_valid;
    logic             output_ready;
    logic             output_last;

    modport master (
        output data_in_valid,
        output data_in,
        output output_ready,
        input  data_in_ready,
        input  data_out,
        input  output_valid,
        input  output_last
    );

    modport slave (
        input  data_in_valid,
        input  data_in,
        input  output_ready,
        output data_in_ready,
        output data_out,
        output output_valid,
        output output_last
    );
endinterface

// File: rtl/fsm_16bit_split.sv
// Splits one IN_W word into two OUT_W halves on a valid/ready stream.
// Define SPLIT_LSB_FIRST_EN to emit the low half first (default: high half).
module fsm_16bit_split #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    fsm_16bit_split_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] word_count
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        EMIT1   = 2'b01,
        EMIT2   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] buf_q, buf_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] first_half;
    logic [OUT_W-1:0] second_half;

`ifdef SPLIT_LSB_FIRST_EN
    assign first_half  = bus.data_in[OUT_W-1:0];
    assign second_half = bus.data_in[IN_W-1:OUT_W];
`else
    assign first_half  = bus.data_in[IN_W-1:OUT_W];
    assign second_half = bus.data_in[OUT_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the second half needs buffering; the first goes straight out.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                vld_d  = 1'b0;
                last_d = 1'b0;
                if (bus.data_in_valid) begin
                    buf_d   = second_half;
                    dout_d  = first_half;
                    vld_d   = 1'b1;
                    state_d = EMIT1;
                end
            end
            EMIT1: begin
                if (bus.output_ready) begin
                    dout_d  = buf_q;
                    last_d  = 1'b1;
                    state_d = EMIT2;
                end
            end
            EMIT2: begin
                if (bus.output_ready) begin
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                vld_d   = 1'b0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_in_ready = (state_q == IDLE);
    assign bus.data_out      = dout_q;
    assign bus.output_valid  = vld_q;
    assign bus.output_last   = last_q;
    assign busy              = (state_q != IDLE);
    assign word_count        = cnt_q;
endmodule
